// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : transaction FSM states
//   owner_t     : which pipeline requester holds the current transaction
//   cnt_width() : watchdog counter width able to hold the value TIMEOUT
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int TIMEOUT_DFLT = 255;
  localparam int CNT_W        = $clog2(TIMEOUT_DFLT + 1);

  // Counter width for an arbiter built with a non-default TIMEOUT.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// txn_watchdog: counts cycles a memory transaction spends waiting for its ack.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : zero the counter (held while the command is issued)
//   i_enable   : advance the counter by one
//   o_expired  : counter has reached TIMEOUT-1
module txn_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (read only) and the memory stage (read/write). One transaction at a time,
// data has fixed priority over fetch. Each transaction: IDLE -> ISSUE ->
// [WAIT...] -> RESP -> IDLE.
//   Fetch port : i_req, i_addr, flush in; i_rdata, i_valid, i_err out
//   Data port  : d_req, d_we, d_addr, d_wdata in; d_rdata, d_valid, d_err out
//   Pipeline   : stall_f, stall_m out
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ack in
//   Status     : busy out (FSM not in IDLE)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0]      i_rdata,
  output logic                  i_valid,
  output logic                  i_err,
  input  logic                  flush,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_valid,
  output logic                  d_err,
  output logic                  stall_f,
  output logic                  stall_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam int WD_W = cnt_width(TIMEOUT);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  owner_t                r_owner;
  logic                  r_discard;
  logic                  r_err;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic [WIDTH-1:0]      r_i_rdata;
  logic [WIDTH-1:0]      r_d_rdata;

  logic w_grant_d;
  logic w_grant_i;
  logic w_capture;
  logic w_timeout;
  logic w_expired;
  logic w_resp;

  txn_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (WD_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ISSUE),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      IDLE: begin
        // Data first: the memory-stage instruction is older than the fetch.
        if (d_req) begin
          w_grant_d    = 1'b1;
          w_next_state = ISSUE;
        end else if (i_req && !flush) begin
          w_grant_i    = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // An ack arriving on the last allowed cycle still counts as success.
        if (mem_ack) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        // No arbitration here: the requester gets one cycle to drop its req.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_I;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      if (w_grant_d) begin
        r_owner     <= OWN_D;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_owner    <= OWN_I;
        r_mem_we   <= 1'b0;
        r_mem_addr <= i_addr;
      end

      if (w_capture || w_timeout) begin
        r_err <= w_timeout;
        if (r_owner == OWN_D) begin
          r_d_rdata <= w_timeout ? '0 : mem_rdata;
        end else begin
          r_i_rdata <= w_timeout ? '0 : mem_rdata;
        end
      end

      // A flushed fetch still finishes on the bus; only its result is dropped.
      if (w_next_state == IDLE) begin
        r_discard <= 1'b0;
      end else if (r_state != IDLE && r_owner == OWN_I && flush) begin
        r_discard <= 1'b1;
      end
    end
  end

  assign w_resp    = (r_state == RESP);
  // flush is also applied combinationally so a flush in RESP itself drops the fetch.
  assign i_valid   = w_resp && (r_owner == OWN_I) && !r_discard && !flush;
  assign d_valid   = w_resp && (r_owner == OWN_D);
  assign i_err     = i_valid && r_err;
  assign d_err     = d_valid && r_err;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_f   = i_req && !i_valid;
  assign stall_m   = d_req && !d_valid;
  assign busy      = (r_state != IDLE);

endmodule
